// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// It produces one quotient bit per cycle and returns {HI=remainder, LO=quotient} with a ready pulse.
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic               signed_div,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               annul,
   output logic               busy,
   output logic               ready,
   output logic [2*WIDTH-1:0] result
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH-1:0]   r_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_result;

   logic               w_accept;
   logic               w_b_zero;
   logic               w_last;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH:0]     w_shift;
   logic               w_ge;
   logic [WIDTH-1:0]   w_rem_nxt;
   logic [WIDTH-1:0]   w_quo_nxt;
   logic [WIDTH-1:0]   w_rem_fix;
   logic [WIDTH-1:0]   w_quo_fix;

   assign w_accept = (r_state == S_IDLE) && start && !annul;
   assign w_b_zero = (b == '0);
   assign w_last   = (r_state == S_CALC) && (r_cnt == LAST);

   // The magnitude of -2^(WIDTH-1) is still correct when it is read back as unsigned.
   assign w_abs_a = (signed_div && a[WIDTH-1]) ? -a : a;
   assign w_abs_b = (signed_div && b[WIDTH-1]) ? -b : b;

   // The quotient register doubles as the dividend shifter; its MSB feeds the remainder.
   assign w_shift   = {r_rem, r_quo[WIDTH-1]};
   assign w_ge      = (w_shift >= {1'b0, r_div});
   assign w_rem_nxt = w_ge ? (w_shift[WIDTH-1:0] - r_div) : w_shift[WIDTH-1:0];
   assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

   // The sign fix works on the final iteration's values, so the result registers on the CALC->DONE edge.
   assign w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
   assign w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      ready       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               busy        = 1'b1;
               w_state_nxt = w_b_zero ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            busy = 1'b1;
            if (annul) begin
               w_state_nxt = S_IDLE;
            end else if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            ready       = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_cnt    <= '0;
         r_result <= '0;
      end else if (w_accept) begin
         r_rem   <= '0;
         r_quo   <= w_abs_a;
         r_div   <= w_abs_b;
         r_neg_q <= signed_div && (a[WIDTH-1] != b[WIDTH-1]);
         r_neg_r <= signed_div && a[WIDTH-1];
         r_cnt   <= '0;
         if (w_b_zero) begin
            r_result <= '0;
         end
      end else if ((r_state == S_CALC) && !annul) begin
         r_rem <= w_rem_nxt;
         r_quo <= w_quo_nxt;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_result <= {w_rem_fix, w_quo_fix};
         end
      end
   end

   assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected {HI,LO} and the ready cycle;
// a negedge monitor pops and compares whenever ready is seen.
module tb_div_unit;

   localparam int unsigned W = 32;

   logic           clk = 1'b0;
   logic           resetn = 1'b1;
   logic           start = 1'b0;
   logic           signed_div = 1'b0;
   logic           annul = 1'b0;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           busy;
   logic           ready;
   logic [2*W-1:0] result;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      logic [63:0] res;
      int          at;
   } exp_t;

   exp_t        sbq[$];
   logic [63:0] last_res = '0;

   div_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .signed_div(signed_div),
      .a         (a),
      .b         (b),
      .annul     (annul),
      .busy      (busy),
      .ready     (ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      if (y == 0) return '0;
      if (!sd) return {x % y, x / y};
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = sx / sy;
      r  = sx % sy;
      return {r[31:0], q[31:0]};
   endfunction

   always @(negedge clk) begin
      if (ready === 1'b1) begin
         if (sbq.size() == 0) begin
            check("spurious_ready", 64'(ready), 64'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("result", result, e.res);
            check("ready_cycle", 64'(cyc), 64'(e.at));
            check("busy_at_ready", 64'(busy), 64'd0);
         end
      end
   end

   task automatic issue(input logic sd, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] e;
      @(posedge clk);
      #1;
      signed_div = sd;
      a          = x;
      b          = y;
      start      = 1'b1;
      e          = ref_div(sd, x, y);
      sbq.push_back('{res: e, at: cyc + ((y == 0) ? 1 : int'(W) + 1)});
      last_res = e;
      #1 check("busy_on_start", 64'(busy), 64'd1);
      @(posedge clk);
      #1;
      start      = 1'b0;
      a          = $urandom;
      b          = $urandom;
      signed_div = 1'($urandom);
   endtask

   task automatic wait_done();
      bit seen = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ready) begin
            seen = 1;
            break;
         end
      end
      if (!seen) check("ready_timeout", 64'(ready), 64'd1);
      @(posedge clk);
   endtask

   initial begin
      #2 resetn = 1'b0;
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_ready", 64'(ready), 64'd0);
      check("reset_result", result, 64'd0);
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;

      issue(1'b0, 32'd7, 32'd2);                 wait_done();
      issue(1'b1, 32'hFFFF_FFF9, 32'd2);         wait_done();
      issue(1'b1, 32'd7, 32'hFFFF_FFFE);         wait_done();
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
      issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
      issue(1'b0, 32'd5, 32'd0);                 wait_done();
      issue(1'b1, 32'hFFFF_FFF0, 32'd0);         wait_done();

      // Annul partway through a division: no ready, and result keeps its previous value.
      begin
         int c0;
         @(posedge clk);
         #1;
         signed_div = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
         c0 = cyc;
         @(posedge clk);
         #1 start = 1'b0;
         while (cyc < c0 + 10) begin
            @(posedge clk);
            #1;
         end
         annul = 1'b1;
         @(posedge clk);
         #1 annul = 1'b0;
         check("busy_after_annul", 64'(busy), 64'd0);
         repeat (40) @(posedge clk);
         #1 check("result_kept_after_annul", result, last_res);
      end
      issue(1'b0, 32'd100, 32'd7); wait_done();

      // Annul and start together while idle: nothing starts.
      @(posedge clk);
      #1;
      a = 32'd9; b = 32'd3; start = 1'b1; annul = 1'b1;
      #1 check("busy_start_annul", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      start = 1'b0; annul = 1'b0;
      check("idle_after_start_annul", 64'(busy), 64'd0);
      repeat (40) @(posedge clk);

      // A second start while busy is ignored and the first result is delivered.
      issue(1'b0, 32'd1000, 32'd3);
      repeat (5) @(posedge clk);
      #1;
      signed_div = 1'b1; a = 32'd50; b = 32'd5; start = 1'b1;
      #1 check("busy_during_ignored_start", 64'(busy), 64'd1);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done();

      // Asynchronous reset mid-operation clears outputs at once, and no ready follows.
      begin
         int c0;
         @(posedge clk);
         #1;
         signed_div = 1'b0; a = 32'd12345; b = 32'd17; start = 1'b1;
         c0 = cyc;
         @(posedge clk);
         #1 start = 1'b0;
         while (cyc < c0 + 15) begin
            @(posedge clk);
            #1;
         end
         #2 resetn = 1'b0;
         #1;
         check("async_reset_busy", 64'(busy), 64'd0);
         check("async_reset_ready", 64'(ready), 64'd0);
         check("async_reset_result", result, 64'd0);
         last_res = '0;
         @(posedge clk);
         #1 resetn = 1'b1;
         repeat (40) @(posedge clk);
         #1 check("result_zero_after_reset", result, 64'd0);
      end

      for (int n = 0; n < 24; n++) begin
         logic [31:0] x, y;
         logic        sd;
         sd = 1'($urandom);
         case ($urandom_range(0, 4))
            0: x = 32'h8000_0000;
            1: x = $urandom_range(0, 1000);
            default: x = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: y = 32'd0;
            1: y = 32'hFFFF_FFFF;
            2: y = $urandom_range(1, 20);
            3: y = 32'd0 - $urandom_range(1, 20);
            default: y = $urandom;
         endcase
         issue(sd, x, y);
         wait_done();
      end

      repeat (5) @(posedge clk);
      check("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
